id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of ControlUnit and the register file.

---
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage.sv | 87 ++++++++
 tb/tb_id_ex_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs (inp_*) and EX-side registered outputs (out_*).
// The master modport is the ID/decode side; the slave modport is the pipeline register.
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              inp_valid;
  logic              inp_flush;
  logic              inp_regDst;
  logic              inp_aluSrc;
  logic              inp_memToReg;
  logic              inp_regWrite;
  logic              inp_memRead;
  logic              inp_memWrite;
  logic              inp_branch;
  logic [1:0]        inp_aluOp;
  logic [DATA_W-1:0] inp_readData1;
  logic [DATA_W-1:0] inp_readData2;
  logic [DATA_W-1:0] inp_imm;
  logic [DATA_W-1:0] inp_pcPlus;
  logic [REG_AW-1:0] inp_rs;
  logic [REG_AW-1:0] inp_rt;
  logic [REG_AW-1:0] inp_rd;
  logic              inp_rtUsed;

  logic              out_regDst;
  logic              out_aluSrc;
  logic              out_memToReg;
  logic              out_regWrite;
  logic              out_memRead;
  logic              out_memWrite;
  logic              out_branch;
  logic [1:0]        out_aluOp;
  logic [DATA_W-1:0] out_readData1;
  logic [DATA_W-1:0] out_readData2;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pcPlus;
  logic [REG_AW-1:0] out_rs;
  logic [REG_AW-1:0] out_writeReg;
  logic              out_valid;
  logic              out_stall;
  logic [CNT_W-1:0]  out_bubbleCnt;

  modport master (
    output inp_valid, inp_flush, inp_regDst, inp_aluSrc, inp_memToReg, inp_regWrite,
           inp_memRead, inp_memWrite, inp_branch, inp_aluOp, inp_readData1, inp_readData2,
           inp_imm, inp_pcPlus, inp_rs, inp_rt, inp_rd, inp_rtUsed,
    input  out_regDst, out_aluSrc, out_memToReg, out_regWrite, out_memRead, out_memWrite,
           out_branch, out_aluOp, out_readData1, out_readData2, out_imm, out_pcPlus,
           out_rs, out_writeReg, out_valid, out_stall, out_bubbleCnt
  );

  modport slave (
    input  inp_valid, inp_flush, inp_regDst, inp_aluSrc, inp_memToReg, inp_regWrite,
           inp_memRead, inp_memWrite, inp_branch, inp_aluOp, inp_readData1, inp_readData2,
           inp_imm, inp_pcPlus, inp_rs, inp_rt, inp_rd, inp_rtUsed,
    output out_regDst, out_aluSrc, out_memToReg, out_regWrite, out_memRead, out_memWrite,
           out_branch, out_aluOp, out_readData1, out_readData2, out_imm, out_pcPlus,
           out_rs, out_writeReg, out_valid, out_stall, out_bubbleCnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush-to-bubble and saturating bubble counter.
// Load-use detection is built only when HAZARD_DETECT_EN is defined; otherwise only flushes bubble.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input logic           inp_clk,
  input logic           inp_rst_n,
  id_ex_stage_if.slave  bus
);

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  // control packing: {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp[1:0]}
  logic [8:0]        ctrl_in;
  logic [8:0]        ctrl_reg;
  logic              valid_reg;
  logic [DATA_W-1:0] rd1_reg, rd2_reg, imm_reg, pc_reg;
  logic [REG_AW-1:0] rs_reg, wr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              haz_cond, haz, bubble;

  assign ctrl_in = {bus.inp_regDst, bus.inp_aluSrc, bus.inp_memToReg, bus.inp_regWrite,
                    bus.inp_memRead, bus.inp_memWrite, bus.inp_branch, bus.inp_aluOp};

  // a load in EX whose result the ID instruction needs cannot be forwarded in time
  assign haz_cond = valid_reg & ctrl_reg[4] & ctrl_reg[5] & (wr_reg != '0) & bus.inp_valid &
                    ((wr_reg == bus.inp_rs) | (bus.inp_rtUsed & (wr_reg == bus.inp_rt)));
  assign haz      = HAZ_EN & haz_cond;
  assign bubble   = bus.inp_flush | haz;

  assign bus.out_stall = haz & ~bus.inp_flush;

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      ctrl_reg  <= '0;
      valid_reg <= 1'b0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      pc_reg    <= '0;
      rs_reg    <= '0;
      wr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      if (bubble) begin
        // data registers keep their old contents; nothing downstream acts on them
        ctrl_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        ctrl_reg  <= bus.inp_valid ? ctrl_in : '0;
        valid_reg <= bus.inp_valid;
        rd1_reg   <= bus.inp_readData1;
        rd2_reg   <= bus.inp_readData2;
        imm_reg   <= bus.inp_imm;
        pc_reg    <= bus.inp_pcPlus;
        rs_reg    <= bus.inp_rs;
        wr_reg    <= bus.inp_regDst ? bus.inp_rd : bus.inp_rt;
      end
      if (bubble && bus.inp_valid && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.out_regDst    = ctrl_reg[8];
  assign bus.out_aluSrc    = ctrl_reg[7];
  assign bus.out_memToReg  = ctrl_reg[6];
  assign bus.out_regWrite  = ctrl_reg[5];
  assign bus.out_memRead   = ctrl_reg[4];
  assign bus.out_memWrite  = ctrl_reg[3];
  assign bus.out_branch    = ctrl_reg[2];
  assign bus.out_aluOp     = ctrl_reg[1:0];
  assign bus.out_readData1 = rd1_reg;
  assign bus.out_readData2 = rd2_reg;
  assign bus.out_imm       = imm_reg;
  assign bus.out_pcPlus    = pc_reg;
  assign bus.out_rs        = rs_reg;
  assign bus.out_writeReg  = wr_reg;
  assign bus.out_valid     = valid_reg;
  assign bus.out_bubbleCnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes hand-computed expectations, monitor compares.
// Expectations follow HAZARD_DETECT_EN so the same vectors cover both builds.
module tb_id_ex_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 2;

`ifdef HAZARD_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  // {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp}
  localparam logic [8:0] ADD = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] LW  = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] SW  = 9'b0_1_0_0_0_1_0_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .inp_clk   (clk),
    .inp_rst_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    bit          is_rst;
    string       name;
    bit          stall;
    bit          valid;
    logic [8:0]  ctrl;
    logic [2:0]  wr;
    logic [2:0]  rs;
    logic [15:0] rd1, rd2, imm, pc;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic [15:0] pc_next = 16'h0040;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, expv);
  endtask

  task automatic drive(input bit v, input bit f, input logic [8:0] c, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] rd, input bit rtu);
    bus.inp_valid     = v;
    bus.inp_flush     = f;
    {bus.inp_regDst, bus.inp_aluSrc, bus.inp_memToReg, bus.inp_regWrite, bus.inp_memRead,
     bus.inp_memWrite, bus.inp_branch, bus.inp_aluOp} = c;
    bus.inp_rs        = rs;
    bus.inp_rt        = rt;
    bus.inp_rd        = rd;
    bus.inp_rtUsed    = rtu;
    bus.inp_readData1 = 16'h1000 + 16'(rs);
    bus.inp_readData2 = 16'h2000 + 16'(rt);
    bus.inp_imm       = 16'hFFF0 | 16'(rd);
    bus.inp_pcPlus    = pc_next;
    pc_next           = pc_next + 16'd1;
  endtask

  task automatic step(input string name, input bit v, input bit f, input logic [8:0] c,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                      input bit rtu, input bit e_stall, input bit e_valid,
                      input logic [8:0] e_ctrl, input logic [2:0] e_wr, input logic [1:0] e_cnt);
    exp_t e;
    @(negedge clk);
    drive(v, f, c, rs, rt, rd, rtu);
    e.is_rst = 1'b0;       e.name = name;        e.stall = e_stall;
    e.valid  = e_valid;    e.ctrl = e_ctrl;      e.wr    = e_wr;
    e.rs     = rs;         e.rd1  = bus.inp_readData1;
    e.rd2    = bus.inp_readData2;                e.imm   = bus.inp_imm;
    e.pc     = bus.inp_pcPlus;                   e.cnt   = e_cnt;
    exp_q.push_back(e);
  endtask

  // drive an instruction, then pull reset low mid-cycle; everything must clear at once
  task automatic reset_mid(input string name, input bit v, input logic [8:0] c,
                           input logic [2:0] rs, input logic [2:0] rt, input bit e_stall);
    exp_t e;
    @(negedge clk);
    drive(v, 1'b0, c, rs, rt, 3'd0, 1'b0);
    e.is_rst = 1'b1; e.name = name; e.stall = e_stall;
    e.valid = 1'b0; e.ctrl = '0; e.wr = '0; e.rs = '0;
    e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.pc = '0; e.cnt = '0;
    exp_q.push_back(e);
    #2 rst_n = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 9'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  // monitor: stall is checked before the edge, registered outputs just after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall", 32'(bus.out_stall), 32'(e.stall));
        if (e.is_rst) #3;
        else begin
          @(posedge clk);
          #1;
        end
        chk(e.name, "valid", 32'(bus.out_valid), 32'(e.valid));
        chk(e.name, "ctrl", 32'({bus.out_regDst, bus.out_aluSrc, bus.out_memToReg,
            bus.out_regWrite, bus.out_memRead, bus.out_memWrite, bus.out_branch,
            bus.out_aluOp}), 32'(e.ctrl));
        chk(e.name, "bubbleCnt", 32'(bus.out_bubbleCnt), 32'(e.cnt));
        if (e.is_rst) begin
          chk(e.name, "stall_after_rst", 32'(bus.out_stall), 32'd0);
          chk(e.name, "writeReg", 32'(bus.out_writeReg), 32'd0);
          chk(e.name, "readData1", 32'(bus.out_readData1), 32'd0);
          chk(e.name, "pcPlus", 32'(bus.out_pcPlus), 32'd0);
        end else if (e.valid) begin
          chk(e.name, "writeReg", 32'(bus.out_writeReg), 32'(e.wr));
          chk(e.name, "rs", 32'(bus.out_rs), 32'(e.rs));
          chk(e.name, "readData1", 32'(bus.out_readData1), 32'(e.rd1));
          chk(e.name, "readData2", 32'(bus.out_readData2), 32'(e.rd2));
          chk(e.name, "imm", 32'(bus.out_imm), 32'(e.imm));
          chk(e.name, "pcPlus", 32'(bus.out_pcPlus), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 9'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    reset_mid("rst_init", 1'b0, 9'd0, 3'd0, 3'd0, 1'b0);

    //    name           v  f  ctrl rs    rt    rd    rtu  stall  valid  ctrl          wr    cnt
    step("pass_add",     1, 0, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     1,     ADD,          3'd3, 2'd0);
    step("load",         1, 0, LW,  3'd1, 3'd2, 3'd0, 0,   0,     1,     LW,           3'd2, 2'd0);
    step("use_rs",       1, 0, ADD, 3'd2, 3'd4, 3'd5, 1,   HD,    !HD,   HD ? 9'd0 : ADD, 3'd5, HD ? 2'd1 : 2'd0);
    step("use_retry",    1, 0, ADD, 3'd2, 3'd4, 3'd5, 1,   0,     1,     ADD,          3'd5, HD ? 2'd1 : 2'd0);
    step("lw_r0",        1, 0, LW,  3'd1, 3'd0, 3'd0, 0,   0,     1,     LW,           3'd0, HD ? 2'd1 : 2'd0);
    step("use_r0",       1, 0, ADD, 3'd0, 3'd0, 3'd6, 1,   0,     1,     ADD,          3'd6, HD ? 2'd1 : 2'd0);
    step("lw_r7",        1, 0, LW,  3'd3, 3'd7, 3'd0, 0,   0,     1,     LW,           3'd7, HD ? 2'd1 : 2'd0);
    step("rt_unused",    1, 0, LW,  3'd1, 3'd7, 3'd0, 0,   0,     1,     LW,           3'd7, HD ? 2'd1 : 2'd0);
    step("flush_haz",    1, 1, ADD, 3'd7, 3'd1, 3'd2, 1,   0,     0,     9'd0,         3'd0, HD ? 2'd2 : 2'd1);
    step("flush_inval",  0, 1, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     0,     9'd0,         3'd0, HD ? 2'd2 : 2'd1);
    step("inval_cap",    0, 0, LW,  3'd1, 3'd2, 3'd0, 0,   0,     0,     9'd0,         3'd0, HD ? 2'd2 : 2'd1);
    step("lw_r3",        1, 0, LW,  3'd1, 3'd3, 3'd0, 0,   0,     1,     LW,           3'd3, HD ? 2'd2 : 2'd1);
    step("use_rt",       1, 0, SW,  3'd2, 3'd3, 3'd0, 1,   HD,    !HD,   HD ? 9'd0 : SW, 3'd3, HD ? 2'd3 : 2'd1);
    step("use_rt_retry", 1, 0, SW,  3'd2, 3'd3, 3'd0, 1,   0,     1,     SW,           3'd3, HD ? 2'd3 : 2'd1);
    step("sat_1",        1, 1, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     0,     9'd0,         3'd0, HD ? 2'd3 : 2'd2);
    step("sat_2",        1, 1, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     0,     9'd0,         3'd0, 2'd3);
    step("sat_3",        1, 1, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     0,     9'd0,         3'd0, 2'd3);
    step("sat_4",        1, 1, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     0,     9'd0,         3'd0, 2'd3);
    step("post_sat",     1, 0, ADD, 3'd4, 3'd5, 3'd6, 1,   0,     1,     ADD,          3'd6, 2'd3);
    step("lw_r2",        1, 0, LW,  3'd1, 3'd2, 3'd0, 0,   0,     1,     LW,           3'd2, 2'd3);
    reset_mid("rst_stall", 1'b1, ADD, 3'd2, 3'd4, HD);
    step("after_rst",    1, 0, ADD, 3'd1, 3'd2, 3'd3, 1,   0,     1,     ADD,          3'd3, 2'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", "pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
